// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and row-drive helper for the 4x4 keypad scanner.
// Build option: define KEYPAD_RELEASE_EVENT_EN to widen key codes and emit release events.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int KEY_CODE_W = 5;
`else
  localparam int KEY_CODE_W = 4;
`endif

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kp_state_t;

  // Active-low one-hot row drive for a row index.
  function automatic logic [NUM_ROWS-1:0] row_onehot_n(input logic [1:0] idx);
    row_onehot_n = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous active-low keypad column inputs.
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_COLS-1:0] col_s
);

  logic [NUM_COLS-1:0] sync_p0;
  logic [NUM_COLS-1:0] sync_p1;

  // Resets to all-high so no phantom key is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= col_in;
      sync_p1 <= sync_p0;
    end
  end

  assign col_s = sync_p1;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobe, press/release debounce, one-deep event holding register.
// Build option: KEYPAD_RELEASE_EVENT_EN adds release events with key_code[4]=1.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_COLS-1:0]   col_in,
  output logic [NUM_ROWS-1:0]   row,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  key_held,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  logic [NUM_COLS-1:0]   col_s;
  logic [CW-1:0]         dwell_cnt;
  logic                  tick;

  kp_state_t             state, state_n;
  logic [1:0]            row_idx, row_idx_n;
  logic [1:0]            col_idx, col_idx_n;
  logic [DW-1:0]         deb_cnt, deb_n;
  logic [DW-1:0]         deb_inc;
  logic                  deb_done;
  logic                  any_low;
  logic [1:0]            low_idx;
  logic                  col_low;

  logic                  push;
  logic [KEY_CODE_W-1:0] push_code;
  logic                  accept, load, drop;

  keypad_col_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .col_in (col_in),
    .col_s  (col_s)
  );

  // Free-running dwell counter; the last cycle of each dwell is the sample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  assign tick     = (dwell_cnt == CW'(SCAN_DIV - 1));
  assign any_low  = ~&col_s;
  assign col_low  = ~col_s[col_idx];
  assign deb_inc  = deb_cnt + 1'b1;
  assign deb_done = (deb_inc == DW'(DEBOUNCE_CNT));

  // Lowest-index low column wins when several are pressed.
  always_comb begin
    low_idx = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) low_idx = 2'(c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_n;
      row_idx <= row_idx_n;
      col_idx <= col_idx_n;
      deb_cnt <= deb_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    col_idx_n = col_idx;
    deb_n     = deb_cnt;
    push      = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            col_idx_n = low_idx;
            deb_n     = DW'(1);
            state_n   = DEB_PRESS;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (col_low) begin
            deb_n = deb_inc;
            if (deb_done) begin
              push    = 1'b1;
              state_n = HELD;
            end
          end else begin
            row_idx_n = row_idx + 2'd1;
            state_n   = SCAN;
          end
        end
        HELD: begin
          if (!col_low) begin
            deb_n   = DW'(1);
            state_n = DEB_REL;
          end
        end
        DEB_REL: begin
          if (!col_low) begin
            deb_n = deb_inc;
            if (deb_done) begin
`ifdef KEYPAD_RELEASE_EVENT_EN
              push      = 1'b1;
`endif
              row_idx_n = row_idx + 2'd1;
              state_n   = SCAN;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  assign push_code = {(state == DEB_REL), row_idx, col_idx};
`else
  assign push_code = {row_idx, col_idx};
`endif

  assign accept = key_valid & key_ready;
  assign load   = push & (~key_valid | key_ready);
  assign drop   = push & key_valid & ~key_ready;

  // One-deep holding register; a push while full and stalled is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        key_code  <= push_code;
        key_valid <= 1'b1;
      end else if (accept) begin
        key_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign row      = row_onehot_n(row_idx);
  assign key_held = (state == HELD) || (state == DEB_REL);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed scoreboard bench for keypad_scan_ctrl with a combinational 4x4 keypad model.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            col_in;
  logic [3:0]            row;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ready;
  logic                  key_held;
  logic                  overflow;
  logic                  ovf_clr;

  logic [15:0]           keys;
  int                    checks;
  int                    errors;
  logic [KEY_CODE_W-1:0] exp_q[$];
  logic [KEY_CODE_W-1:0] mon_exp;

  keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key k pulls column k%4 low while row k/4 is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !row[k/4]) col_in[k%4] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got code %0d, no event required", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_code !== mon_exp) begin
          errors++;
          $display("FAIL event_code: got %0d, required %0d", key_code, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] probe(input int which);
    case (which)
      0:       probe = {3'b000, key_held};
      1:       probe = {3'b000, key_valid};
      default: probe = row;
    endcase
  endfunction

  // which: 0 key_held, 1 key_valid, 2 row
  task automatic wait_for(input int which, input logic [3:0] v, input int budget,
                          input string nm, output int n);
    n = 0;
    while (probe(which) !== v && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (probe(which) !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, value %0h, required %0h", nm, n, probe(which), v);
    end
  endtask

  initial begin
    logic [3:0] exp_rows [5];
    int  n;
    bit  held_seen, valid_seen, row2_seen;

    checks    = 0;
    errors    = 0;
    keys      = '0;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", key_code, 0);
    rst_n = 1'b1;

    // Idle scan: one row per 8-cycle dwell
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("idle_row%0d", i), row, exp_rows[i]);
      repeat (8) @(posedge clk);
      #1;
    end
    chk("idle_valid", key_valid, 0);

    // Key 4 held with consumer ready
    key_ready = 1'b1;
    exp_q.push_back(KEY_CODE_W'(4));
    keys[4] = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("k4_held", key_held, 1);
    chk("k4_valid_drained", key_valid, 0);
    chk("k4_one_event", exp_q.size(), 0);
    keys[4] = 1'b0;
    wait_for(0, 4'd0, 40, "k4_release", n);
    chk("k4_release_latency", (n >= 19 && n <= 26), 1);
    chk("k4_resume_row", row, 4'b1011);

    // Key 5 bounce: low for a single dwell only
    wait_for(2, 4'b1101, 40, "k5_row_wait", n);
    keys[5] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    keys[5] = 1'b0;
    held_seen = 0; valid_seen = 0; row2_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (key_held)  held_seen  = 1;
      if (key_valid) valid_seen = 1;
      if (row == 4'b1011) row2_seen = 1;
    end
    chk("k5_no_held", held_seen, 0);
    chk("k5_no_event", valid_seen, 0);
    chk("k5_scan_continues", row2_seen, 1);
    chk("pre_ovf", overflow, 0);

    // Stalled consumer: press/release 6, then press 9 is dropped
    key_ready = 1'b0;
    exp_q.push_back(KEY_CODE_W'(6));
    keys[6] = 1'b1;
    wait_for(1, 4'd1, 80, "k6_valid", n);
    chk("k6_code", key_code, 6);
    keys[6] = 1'b0;
    wait_for(0, 4'd0, 40, "k6_release", n);
    chk("k6_code_hold", key_code, 6);
    keys[9] = 1'b1;
    wait_for(0, 4'd1, 80, "k9_held", n);
    chk("k9_ovf", overflow, 1);
    chk("k9_valid", key_valid, 1);
    chk("k9_code_kept", key_code, 6);
    keys[9] = 1'b0;
    wait_for(0, 4'd0, 40, "k9_release", n);
    chk("k9_code_kept2", key_code, 6);
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid", key_valid, 0);
    chk("ovf_before_clr", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Keys 0 and 3 together: lowest column wins
    exp_q.push_back(KEY_CODE_W'(0));
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    wait_for(0, 4'd1, 80, "k03_held", n);
    repeat (2) @(posedge clk);
    #1;
    keys[0] = 1'b0;
    keys[3] = 1'b0;
    wait_for(0, 4'd0, 40, "k03_release", n);
    chk("k03_consumed", exp_q.size(), 0);

    // Asynchronous reset while held
    key_ready = 1'b0;
    keys[10] = 1'b1;
    wait_for(0, 4'd1, 80, "k10_held", n);
    chk("k10_valid", key_valid, 1);
    chk("k10_code", key_code, 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_held", key_held, 0);
    chk("arst_valid", key_valid, 0);
    chk("arst_row", row, 4'b1110);
    keys[10] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_row", row, 4'b1110);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
